// File: rtl/debouncer_button_array_if.sv
// Signal bundle for debouncer_button_array: raw button inputs, conditioned outputs
// and a per-channel FSM state view (2 bits per channel) for checkers.
interface debouncer_button_array_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   noisy;
  logic [N_CH-1:0]   debounced;
  logic [N_CH-1:0]   p_edge;
  logic [N_CH-1:0]   n_edge;
  logic [N_CH-1:0]   edge_detected;
  logic [N_CH-1:0]   long_press;
  logic              any_event;
  logic [2*N_CH-1:0] state_dbg;

  // No valid/ready handshake: noisy is sampled every cycle, outputs are level/pulse.
  modport master (
    output noisy,
    input  debounced, p_edge, n_edge, edge_detected, long_press, any_event, state_dbg
  );

  modport slave (
    input  noisy,
    output debounced, p_edge, n_edge, edge_detected, long_press, any_event, state_dbg
  );
endinterface

// File: rtl/debouncer_button_array.sv
// N-channel button conditioner: 2-FF sync, counter debounce, edge pulses, long press.
// Optional auto-repeat of long_press is enabled by defining BTN_AUTO_REPEAT_EN.
module debouncer_button_array #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int HOLD_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic                     clk,
  input  logic                     reset,
  debouncer_button_array_if.slave  bus
);

  localparam int MAX_SH  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int MAX_ALL = (MAX_SH > REPEAT_CYCLES) ? MAX_SH : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_PRE    = CW'(HOLD_CYCLES - 2);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } state_t;

  logic [N_CH-1:0]   s1_q, s2_q;
  logic [N_CH-1:0]   deb_v, pe_v, ne_v, ed_v, lp_v;
  logic [2*N_CH-1:0] state_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.noisy;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t        state_q;
    logic [CW-1:0] cnt_q, hold_q, hold_nxt;
    logic          deb_q, pe_q, ne_q, ed_q, lp_q;
    logic          s, stable_hit, enter_high, exit_high, holding, lp_nxt;
`ifdef BTN_AUTO_REPEAT_EN
    logic [CW-1:0] rep_q, rep_nxt;
`endif

    always_comb begin
      s          = s2_q[i];
      stable_hit = (cnt_q == STABLE_LAST);
      enter_high = (state_q == ST_RISE_CHK) && s && stable_hit;
      exit_high  = (state_q == ST_FALL_CHK) && !s && stable_hit;
      // The cycle that drops debounced does not age the hold count nor fire long_press.
      holding    = ((state_q == ST_HIGH) || (state_q == ST_FALL_CHK)) && !exit_high;
      hold_nxt   = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
      lp_nxt     = (hold_q == HOLD_PRE);
`ifdef BTN_AUTO_REPEAT_EN
      rep_nxt    = '0;
      if (hold_q == HOLD_LAST) begin
        if (rep_q == REPEAT_LAST) begin
          lp_nxt = 1'b1;
        end else begin
          rep_nxt = rep_q + 1'b1;
        end
      end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_LOW;
        cnt_q   <= '0;
        deb_q   <= 1'b0;
        pe_q    <= 1'b0;
        ne_q    <= 1'b0;
        ed_q    <= 1'b0;
      end else begin
        pe_q <= enter_high;
        ne_q <= exit_high;
        ed_q <= enter_high | exit_high;
        case (state_q)
          ST_LOW: begin
            if (s) begin
              state_q <= ST_RISE_CHK;
              cnt_q   <= CW'(1);
            end
          end
          ST_RISE_CHK: begin
            if (!s) begin
              state_q <= ST_LOW;
              cnt_q   <= '0;
            end else if (stable_hit) begin
              state_q <= ST_HIGH;
              cnt_q   <= '0;
              deb_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_HIGH: begin
            if (!s) begin
              state_q <= ST_FALL_CHK;
              cnt_q   <= CW'(1);
            end
          end
          ST_FALL_CHK: begin
            if (s) begin
              state_q <= ST_HIGH;
              cnt_q   <= '0;
            end else if (stable_hit) begin
              state_q <= ST_LOW;
              cnt_q   <= '0;
              deb_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_q <= '0;
        lp_q   <= 1'b0;
      end else begin
        hold_q <= holding ? hold_nxt : '0;
        lp_q   <= holding && lp_nxt;
      end
    end

`ifdef BTN_AUTO_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rep_q <= '0;
      end else begin
        rep_q <= holding ? rep_nxt : '0;
      end
    end
`endif

    assign deb_v[i]           = deb_q;
    assign pe_v[i]            = pe_q;
    assign ne_v[i]            = ne_q;
    assign ed_v[i]            = ed_q;
    assign lp_v[i]            = lp_q;
    assign state_v[2*i +: 2]  = state_q;
  end

  assign bus.debounced     = deb_v;
  assign bus.p_edge        = pe_v;
  assign bus.n_edge        = ne_v;
  assign bus.edge_detected = ed_v;
  assign bus.long_press    = lp_v;
  assign bus.any_event     = |(ed_v | lp_v);
  assign bus.state_dbg     = state_v;

endmodule

// File: tb/tb_debouncer_button_array.sv
// Bench for debouncer_button_array: run-length/age reference model checked every
// cycle, plus directed literal checks of latency, glitch, long press and reset.
module tb_debouncer_button_array;
  localparam int N_CH   = 2;
  localparam int STABLE = 4;
  localparam int HOLD   = 10;
  localparam int REPEAT = 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  debouncer_button_array_if #(.N_CH(N_CH)) bus ();

  debouncer_button_array #(
    .N_CH          (N_CH),
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REPEAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: debounced flips once the synchronised input has differed
  // from it for STABLE consecutive cycles; long press fires by age since rise.
  logic [N_CH-1:0] e_deb, e_pe, e_ne, e_lp, h1, h2;
  int              run [N_CH];
  int              age [N_CH];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_deb <= '0; e_pe <= '0; e_ne <= '0; e_lp <= '0;
      h1 <= '0; h2 <= '0;
      for (int c = 0; c < N_CH; c++) begin
        run[c] <= 0;
        age[c] <= 0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        int   r, a;
        logic d, pe, ne, lp;
        r = run[c]; a = age[c]; d = e_deb[c];
        pe = 1'b0; ne = 1'b0; lp = 1'b0;
        if (h2[c] != d) r = r + 1;
        else            r = 0;
        if (r == STABLE) begin
          d = ~d; r = 0; a = 0;
          pe = d; ne = ~d;
        end else if (d) begin
          a = a + 1;
          if (a == HOLD - 1) lp = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          if (a > HOLD - 1 && ((a - (HOLD - 1)) % REPEAT) == 0) lp = 1'b1;
`endif
        end
        run[c]   <= r;
        age[c]   <= a;
        e_deb[c] <= d;
        e_pe[c]  <= pe;
        e_ne[c]  <= ne;
        e_lp[c]  <= lp;
      end
      h1 <= bus.noisy;
      h2 <= h1;
    end
  end

  // scoreboard: every cycle against the model
  always @(negedge clk) begin
    cmp("m_debounced", 8'(bus.debounced), 8'(e_deb));
    cmp("m_p_edge", 8'(bus.p_edge), 8'(e_pe));
    cmp("m_n_edge", 8'(bus.n_edge), 8'(e_ne));
    cmp("m_edge_detected", 8'(bus.edge_detected), 8'(e_pe | e_ne));
    cmp("m_long_press", 8'(bus.long_press), 8'(e_lp));
    cmp("m_any_event", 8'(bus.any_event), 8'(|(e_pe | e_ne | e_lp)));
    cmp("m_edge_excl", 8'(bus.p_edge & bus.n_edge), 8'd0);
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_debounced"}, 8'(bus.debounced), 8'd0);
    cmp({tag, "_p_edge"}, 8'(bus.p_edge), 8'd0);
    cmp({tag, "_n_edge"}, 8'(bus.n_edge), 8'd0);
    cmp({tag, "_edge_det"}, 8'(bus.edge_detected), 8'd0);
    cmp({tag, "_long_press"}, 8'(bus.long_press), 8'd0);
    cmp({tag, "_any_event"}, 8'(bus.any_event), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.noisy = '0;
    step(2);
    reset = 1'b0;
    step(2);

    // Press both, then async reset mid-cycle, then re-acquire
    bus.noisy = 2'b11;
    step(6);
    cmp("pre_reset_deb", 8'(bus.debounced), 8'h03);
    #3 reset = 1'b1;
    #1 check_all_zero("async_reset");
    step(1);
    reset = 1'b0;
    step(5);
    cmp("rst_rel_deb_e5", 8'(bus.debounced), 8'h00);
    step(1);
    cmp("rst_rel_deb_e6", 8'(bus.debounced), 8'h03);
    cmp("rst_rel_pedge_e6", 8'(bus.p_edge), 8'h03);
    bus.noisy = 2'b00;
    step(12);

    // Glitch of 3 cycles on channel 0
    bus.noisy[0] = 1'b1;
    step(3);
    bus.noisy[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      cmp("glitch_deb0", 8'(bus.debounced[0]), 8'd0);
      cmp("glitch_pedge0", 8'(bus.p_edge[0]), 8'd0);
      cmp("glitch_any", 8'(bus.any_event), 8'd0);
    end

    // Clean press/release on channel 1
    bus.noisy[1] = 1'b1;
    step(5);
    cmp("press1_deb_e5", 8'(bus.debounced), 8'h00);
    step(1);
    cmp("press1_pedge", 8'(bus.p_edge), 8'h02);
    cmp("press1_edet", 8'(bus.edge_detected), 8'h02);
    cmp("press1_deb", 8'(bus.debounced), 8'h02);
    step(1);
    cmp("press1_pedge_off", 8'(bus.p_edge), 8'h00);
    step(13);
    bus.noisy[1] = 1'b0;
    step(5);
    cmp("rel1_deb_e5", 8'(bus.debounced), 8'h02);
    step(1);
    cmp("rel1_nedge", 8'(bus.n_edge), 8'h02);
    cmp("rel1_edet", 8'(bus.edge_detected), 8'h02);
    cmp("rel1_deb", 8'(bus.debounced), 8'h00);
    step(1);
    cmp("rel1_nedge_off", 8'(bus.n_edge), 8'h00);
    step(10);

    // Long press on channel 0
    bus.noisy[0] = 1'b1;
    step(6);
    cmp("lp_pedge", 8'(bus.p_edge), 8'h01);
    step(8);
    cmp("lp_early", 8'(bus.long_press), 8'h00);
    step(1);
    cmp("lp_fire", 8'(bus.long_press), 8'h01);
    cmp("lp_any", 8'(bus.any_event), 8'h01);
`ifdef BTN_AUTO_REPEAT_EN
    step(1);
    cmp("lp_rep_gap1", 8'(bus.long_press), 8'h00);
    step(1);
    cmp("lp_rep_gap2", 8'(bus.long_press), 8'h00);
    step(1);
    cmp("lp_rep_fire", 8'(bus.long_press), 8'h01);
    step(12);
`else
    for (int k = 0; k < 15; k++) begin
      step(1);
      cmp("lp_single", 8'(bus.long_press), 8'h00);
    end
`endif
    bus.noisy[0] = 1'b0;
    step(12);

    // Simultaneous press, reset at hold count 5, then re-acquire from scratch
    bus.noisy = 2'b11;
    step(6);
    cmp("sim_pedge", 8'(bus.p_edge), 8'h03);
    cmp("sim_edet", 8'(bus.edge_detected), 8'h03);
    cmp("sim_any", 8'(bus.any_event), 8'h01);
    step(5);
    #3 reset = 1'b1;
    #1 check_all_zero("mid_hold_reset");
    step(1);
    reset = 1'b0;
    step(6);
    cmp("sim2_pedge", 8'(bus.p_edge), 8'h03);
    for (int k = 0; k < 8; k++) begin
      step(1);
      cmp("sim2_no_lp", 8'(bus.long_press), 8'h00);
    end
    step(1);
    cmp("sim2_lp", 8'(bus.long_press), 8'h03);
    bus.noisy = 2'b00;
    step(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/debouncer_button_array.md
Name: debouncer_button_array

Overview:
- N-channel parametrised button conditioner: 2-FF synchroniser, counter-based debounce, per-channel edge pulses and long-press detection.
- Sits between raw board push-buttons/switches and control FSMs.
- Replaces per-button debouncer plus edge-detector pairs with one configurable block.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- STABLE_CYCLES, 500000, consecutive synchronised cycles at the new level required to accept a change (>=2; 5 ms at 100 MHz).
- HOLD_CYCLES, 100000000, cycles debounced must stay high before long_press fires (> STABLE_CYCLES).
- REPEAT_CYCLES, 20000000, auto-repeat period; used only with BTN_AUTO_REPEAT_EN (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state.
- noisy  in  N_CH  raw asynchronous button inputs, bit i = channel i.
- debounced  out  N_CH  filtered level per channel.
- p_edge  out  N_CH  1-cycle pulse when debounced[i] rises.
- n_edge  out  N_CH  1-cycle pulse when debounced[i] falls.
- edge_detected  out  N_CH  p_edge | n_edge.
- long_press  out  N_CH  1-cycle pulse at hold threshold (and on repeats if enabled).
- any_event  out  1  OR-reduction of edge_detected and long_press, same cycle.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Reset forces every output, synchroniser flop, counter and FSM to 0/LOW immediately, independent of clk. Reset mid-operation discards partial counts; no edge pulse on or after deassertion unless the input then meets STABLE_CYCLES again.
- Synchroniser: noisy[i] -> s1 -> s2, both registered. Debounce logic sees s2 only.
- Per-channel FSM, 4 states:
  - LOW: debounced=0. s2=1 -> RISE_CHK, cnt=1.
  - RISE_CHK: s2=0 -> LOW, cnt=0. s2=1 and cnt==STABLE_CYCLES-1 -> HIGH, debounced<=1, p_edge<=1 for one cycle. Else cnt++.
  - HIGH: debounced=1. s2=0 -> FALL_CHK, cnt=1.
  - FALL_CHK: s2=1 -> HIGH, cnt=0. s2=0 and cnt==STABLE_CYCLES-1 -> LOW, debounced<=0, n_edge<=1. Else cnt++.
- Latency: raw step held clean -> debounced and edge pulse change on clock edge STABLE_CYCLES+2 after first sampling edge.
- Glitch shorter than STABLE_CYCLES synchronised cycles: no output change, no pulse.
- All outputs registered; p_edge/n_edge/edge_detected/long_press assert in the same cycle as the debounced transition they relate to.
- Counter width: $clog2(max(STABLE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1). Counters never wrap.
- Hold counter per channel:
  - Cleared on entry to HIGH; increments each cycle in HIGH or FALL_CHK.
  - Reaching HOLD_CYCLES-1 -> long_press pulse, then counter saturates.
  - Cleared on return to LOW.
  - Bounce back from FALL_CHK to HIGH keeps the hold count.
- p_edge and n_edge never both set on one channel in one cycle. Channels fully independent; simultaneous events on several channels all reported.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: after the first long_press, channel keeps pulsing long_press every REPEAT_CYCLES cycles while debounced stays high. Repeat counter restarts at each pulse and clears on return to LOW.
- Undefined: one long_press per press. No repeat counter is synthesised and REPEAT_CYCLES is ignored.

Test Plan:
Bench parameters: N_CH=2, STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Reset: reset=1 asynchronously mid-cycle with noisy=2'b11 -> all outputs 0 immediately; after release with noisy held, debounced[0] rises with p_edge[0]=1 exactly 6 edges later.
- Glitch rejection: noisy[0] high 3 cycles then low -> debounced, p_edge, any_event stay 0 throughout.
- Clean press/release: noisy[1] high 20 cycles -> p_edge[1] single pulse, debounced[1]=1; on release n_edge[1] single pulse 6 edges after the fall; edge_detected mirrors both.
- Long press: noisy[0] held 30 cycles -> long_press[0] once, 9 cycles after p_edge[0]. With BTN_AUTO_REPEAT_EN: further pulses every 3 cycles until release. Without: no further pulses.
- Simultaneous channels, mid-hold reset: both bits rise same cycle -> p_edge=2'b11 same cycle, any_event=1; reset asserted at hold count 5 -> no long_press, all counters cleared.
